dispense_arbiter: RTL
=====================

# dispense_arbiter

Shares the vending machine's single dispense mechanism between two customer front panels. Each panel's vend FSM raises a request with a validated item code once payment succeeds. This block arbitrates round-robin, latches the winning code, and drives the motor for a fixed duration. It then reports completion, and optionally a jam, back to the winning panel.

## Interface

Parameters:
- DISPENSE_CYCLES, default 4: number of cycles MOTOR_ON is held high; legal range 1..15.
- COOLDOWN_CYCLES, default 2: number of idle cycles after each dispense before the next grant; legal range 1..15.

Ports:
- CLK  input  1: single clock; all state changes on posedge CLK.
- RESET  input  1: synchronous, active-high reset.
- REQ0 / REQ1  input  1 each: level requests from panel 0 and panel 1. The requester holds REQ until it sees its GNT.
- CODE0 / CODE1  input  6 each: item code {row[2:0], col[2:0]} from each panel. Must be stable while the matching REQ is high.
- DROP_SENSE  input  1: drop sensor; high for one or more cycles when an item falls.
- GNT0 / GNT1  output  1 each: one-cycle grant pulse to the winning panel.
- MOTOR_ON  output  1: dispense motor enable.
- MOTOR_SEL  output  6: latched item code of the current dispense.
- DONE0 / DONE1  output  1 each: one-cycle completion pulse to the served panel.
- ERR  output  1: valid only with a DONE pulse; 1 means no drop was detected.
- BUSY  output  1: high in every state except IDLE.
- FAULT  output  1: sticky jam indicator.

## Operation

- The FSM has four states: IDLE, GRANT, DISPENSE and COOLDOWN. The state register and all outputs are registered; there is no combinational input-to-output path.
- All outputs reset to 0. The round-robin pointer `last` resets to 1, so panel 0 wins the first tie. Both counters and the drop-seen flag reset to 0.
- **IDLE**
  - If FAULT=1, stay in IDLE and ignore all requests.
  - If only one REQ is high, that panel wins.
  - If both REQs are high, the panel other than `last` wins.
  - On a win, go to GRANT.
- **GRANT** (one cycle)
  - Assert the winner's GNT.
  - Latch the winner's CODE into MOTOR_SEL.
  - Set `last` to the winner.
  - Clear the drop-seen flag and the counter.
  - Go to DISPENSE.
- **DISPENSE**
  - MOTOR_ON=1 for exactly DISPENSE_CYCLES cycles, counted by a 4-bit counter.
  - Any DROP_SENSE=1 during these cycles sets the drop-seen flag.
  - Go to COOLDOWN after the last cycle.
- **COOLDOWN**
  - Lasts COOLDOWN_CYCLES cycles.
  - On the first cycle, pulse the winner's DONE and drive ERR = !drop-seen.
  - If ERR=1, set FAULT (see Configuration).
  - Return to IDLE after the last cycle.
- MOTOR_SEL holds its value until the next GRANT.
- A panel must drop REQ in the cycle after its GNT. A REQ still high when the FSM returns to IDLE is treated as a new request.
- DROP_SENSE outside DISPENSE is ignored.
- Only one panel can be granted at a time. GNT0 and GNT1 are never high together, and neither are DONE0 and DONE1.

## Timing

- Nominal sequence, with REQx first sampled high in IDLE at edge k:
  - GNTx is high during cycle k+1.
  - MOTOR_ON is high during cycles k+2 through k+1+DISPENSE_CYCLES.
  - DONEx is high during cycle k+2+DISPENSE_CYCLES.
  - The FSM is back in IDLE at cycle k+2+DISPENSE_CYCLES+COOLDOWN_CYCLES.
- With the defaults:
  - Request-to-DONE latency is 6 cycles from the sampling edge.
  - The minimum grant-to-grant spacing is 1+4+2+1 = 8 cycles.
- Arbitration is evaluated only in IDLE. A request arriving in GRANT, DISPENSE or COOLDOWN waits and never preempts the current dispense.
- RESET asserted at any cycle takes effect at that edge:
  - MOTOR_ON drops on the next cycle.
  - No DONE is issued for the aborted dispense.
  - FAULT clears.
  - `last` returns to 1.
- Panel requests that arrive together after reset are served 0, 1, 0, 1, ... indefinitely, so there is no starvation.

## Configuration

- **JAM_DETECT_EN defined**
  - The drop-seen flag is implemented.
  - ERR = !drop-seen at DONE.
  - ERR=1 sets FAULT. FAULT holds until RESET, and while it is set the arbiter issues no grants.
- **JAM_DETECT_EN undefined**
  - DROP_SENSE is ignored.
  - ERR is tied to 0.
  - FAULT is tied to 0.
  - Every dispense completes as a success.

## Test plan

- **Single request:** reset, then REQ0=1 with CODE0=6'o13.
  - GNT0 pulses 1 cycle after sampling.
  - MOTOR_SEL=6'o13 and MOTOR_ON is high for 4 cycles.
  - DONE0 pulses with ERR=0 (DROP_SENSE pulsed in motor cycle 2).
  - BUSY is low 8 cycles after GNT0.
- **Simultaneous requests after reset:** REQ0=REQ1=1, each requester re-raising REQ after its grant.
  - Grant order is GNT0, GNT1, GNT0.
  - Consecutive grants are 8 cycles apart, and DONE goes only to the granted panel.
- **Late request:** REQ1 rises during panel 0's DISPENSE.
  - MOTOR_ON is not disturbed.
  - GNT1 follows the first IDLE cycle after COOLDOWN.
- **Jam (JAM_DETECT_EN defined):** no DROP_SENSE during DISPENSE.
  - DONE0 and ERR=1 pulse together, and FAULT=1.
  - A subsequent REQ1 gets no grant until RESET, after which FAULT=0 and REQ1 is granted.
- **Reset mid-dispense:** assert RESET in motor cycle 2.
  - MOTOR_ON=0 on the next cycle, with no DONE.
  - All outputs are 0.
  - After RESET releases, a pending REQ0/REQ1 tie goes to panel 0.
- **Macro off:** repeat the jam stimulus with JAM_DETECT_EN undefined.
  - DONE0 pulses with ERR=0, FAULT stays 0, and the next request is granted normally.

Source files
------------

// File: rtl/dispense_arbiter.sv
// dispense_arbiter: shares one dispense motor between two vending panels.
// Round-robin grant, latched item code, timed motor run, DONE/ERR report.
//
// Ports:
//   CLK, RESET           clock, synchronous active-high reset
//   REQ0/REQ1            level requests, held until the matching GNT
//   CODE0/CODE1          item codes {row,col}, stable while REQ is high
//   DROP_SENSE           drop sensor, sampled only while dispensing
//   GNT0/GNT1            one-cycle grant pulse to the winning panel
//   MOTOR_ON, MOTOR_SEL  motor enable and latched item code
//   DONE0/DONE1          one-cycle completion pulse to the served panel
//   ERR                  with DONE: 1 means no drop was seen
//   BUSY                 high whenever the FSM is not idle
//   FAULT                sticky jam flag, blocks further grants
//
// Parameters: DISPENSE_CYCLES (1..15), COOLDOWN_CYCLES (1..15).
// Optional feature macro: JAM_DETECT_EN enables the drop-seen flag,
// ERR and the sticky FAULT. Without it every dispense reports success.

module dispense_arbiter #(
    parameter int unsigned DISPENSE_CYCLES = 4,
    parameter int unsigned COOLDOWN_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic [5:0] CODE0,
    input  logic [5:0] CODE1,
    input  logic       DROP_SENSE,
    output logic       GNT0,
    output logic       GNT1,
    output logic       MOTOR_ON,
    output logic [5:0] MOTOR_SEL,
    output logic       DONE0,
    output logic       DONE1,
    output logic       ERR,
    output logic       BUSY,
    output logic       FAULT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_DISPENSE,
        S_COOLDOWN
    } state_e;

    // Terminal counts for the shared 4-bit phase counter.
    localparam logic [3:0] DISP_LAST = 4'(DISPENSE_CYCLES - 1);
    localparam logic [3:0] COOL_LAST = 4'(COOLDOWN_CYCLES - 1);

    state_e     state_q;
    logic [3:0] cnt_q;
    logic       last_q;
    logic       win_q;
    logic       gnt0_q;
    logic       gnt1_q;
    logic       motor_q;
    logic [5:0] sel_q;
    logic       done0_q;
    logic       done1_q;
    logic       busy_q;

    logic       win_d;
    logic       start_d;

`ifdef JAM_DETECT_EN
    logic drop_q;
    logic err_q;
    logic fault_q;
    logic drop_now;

    // Includes the sensor value of the final motor cycle.
    assign drop_now = drop_q | DROP_SENSE;
    assign ERR      = err_q;
    assign FAULT    = fault_q;
    assign start_d  = (REQ0 | REQ1) & ~fault_q;
`else
    logic unused_drop;

    assign unused_drop = DROP_SENSE;
    assign ERR         = 1'b0;
    assign FAULT       = 1'b0;
    assign start_d     = REQ0 | REQ1;
`endif

    // A tie goes to the panel that was not served last.
    always_comb begin
        win_d = 1'b0;
        unique case ({REQ1, REQ0})
            2'b01:   win_d = 1'b0;
            2'b10:   win_d = 1'b1;
            2'b11:   win_d = ~last_q;
            default: win_d = 1'b0;
        endcase
    end

    assign GNT0      = gnt0_q;
    assign GNT1      = gnt1_q;
    assign MOTOR_ON  = motor_q;
    assign MOTOR_SEL = sel_q;
    assign DONE0     = done0_q;
    assign DONE1     = done1_q;
    assign BUSY      = busy_q;

    // Outputs are set on the edge that enters a state, so each one is
    // valid for exactly the cycles the FSM spends in that state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            motor_q <= 1'b0;
            sel_q   <= 6'd0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef JAM_DETECT_EN
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
            fault_q <= 1'b0;
`endif
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
`ifdef JAM_DETECT_EN
            err_q   <= 1'b0;
`endif
            unique case (state_q)
                S_IDLE: begin
                    if (start_d) begin
                        state_q <= S_GRANT;
                        busy_q  <= 1'b1;
                        win_q   <= win_d;
                        last_q  <= win_d;
                        gnt0_q  <= ~win_d;
                        gnt1_q  <= win_d;
                        sel_q   <= win_d ? CODE1 : CODE0;
                        cnt_q   <= 4'd0;
`ifdef JAM_DETECT_EN
                        drop_q  <= 1'b0;
`endif
                    end
                end
                S_GRANT: begin
                    state_q <= S_DISPENSE;
                    motor_q <= 1'b1;
                end
                S_DISPENSE: begin
`ifdef JAM_DETECT_EN
                    drop_q <= drop_now;
`endif
                    if (cnt_q == DISP_LAST) begin
                        state_q <= S_COOLDOWN;
                        motor_q <= 1'b0;
                        cnt_q   <= 4'd0;
                        done0_q <= ~win_q;
                        done1_q <= win_q;
`ifdef JAM_DETECT_EN
                        err_q   <= ~drop_now;
                        fault_q <= fault_q | ~drop_now;
`endif
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_COOLDOWN: begin
                    if (cnt_q == COOL_LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    motor_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
